// File: rtl/spm_pkg.sv
// Shared types and constants for the SPM stream driver and its deserialiser.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } spm_state_e;

    localparam int SPM_DRV_ACC_GUARD = 8;

    // Width of a counter that must reach 2*size inclusive.
    function automatic int spm_cnt_w(input int size);
        return $clog2(2 * size + 1);
    endfunction

endpackage

// File: rtl/spm_deser.sv
// Serial product capture into a 2*SIZE-bit register, with the optional accumulator
// enabled by SPM_DRV_ACCUM_EN.
module spm_deser
    import spm_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_shift,
    input  logic i_bit,
`ifdef SPM_DRV_ACCUM_EN
    input  logic i_last,
    input  logic i_acc_clr,
    output logic [2*SIZE+SPM_DRV_ACC_GUARD-1:0] o_product
`else
    output logic [2*SIZE-1:0] o_product
`endif
);
    localparam int PW = 2 * SIZE;

    logic signed [PW-1:0] r_prod;
    logic signed [PW-1:0] w_prod_nxt;

    // LSB arrives first, so each new bit enters at the top and drifts down.
    assign w_prod_nxt = {i_bit, r_prod[PW-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else if (i_shift) begin
            r_prod <= w_prod_nxt;
        end
    end

`ifdef SPM_DRV_ACCUM_EN
    localparam int AW = PW + SPM_DRV_ACC_GUARD;

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_prod_ext;

    assign w_prod_ext = {{SPM_DRV_ACC_GUARD{w_prod_nxt[PW-1]}}, w_prod_nxt};

    // The final bit is only present in w_prod_nxt, so accumulate from it rather than r_prod.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_last) begin
            r_acc <= (i_acc_clr ? '0 : r_acc) + w_prod_ext;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end
    end

    assign o_product = r_acc;
`else
    assign o_product = r_prod;
`endif

endmodule

// File: rtl/spm_stream_driver.sv
// Sequencer around the serial-parallel multiplier array: parallel x, serial sign-extended y,
// serial product deserialised to a signed result. Optional accumulator via SPM_DRV_ACCUM_EN.
module spm_stream_driver
    import spm_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_x,
    input  logic [SIZE-1:0] in_y,
    output logic            spm_rst,
    output logic [SIZE-1:0] spm_x,
    output logic            spm_y,
    input  logic            spm_p,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef SPM_DRV_ACCUM_EN
    input  logic            acc_clr,
    output logic [2*SIZE+SPM_DRV_ACC_GUARD-1:0] out_product
`else
    output logic [2*SIZE-1:0] out_product
`endif
);
    localparam int PW = 2 * SIZE;
    localparam int CW = spm_cnt_w(SIZE);

    spm_state_e              r_state;
    spm_state_e              w_state_nxt;
    logic [CW-1:0]           r_k;
    logic signed [SIZE-1:0]  r_x;
    logic signed [SIZE-1:0]  r_ysh;
    logic                    r_spm_rst;
    logic                    w_accept;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_spm_y;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        w_spm_y     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = in_valid;
                if (in_valid) w_state_nxt = CLR;
            end
            CLR: w_state_nxt = RUN;
            RUN: begin
                // k=0 only drives y; the array's first product bit is captured at k=1.
                w_spm_y = (r_k < CW'(PW)) ? r_ysh[0] : 1'b0;
                w_shift = (r_k != '0);
                w_last  = (r_k == CW'(PW));
                if (w_last) w_state_nxt = DONE;
            end
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_x       <= '0;
            r_ysh     <= '0;
            r_spm_rst <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            // Registered so the array clear is a clean level covering exactly the CLR cycle.
            r_spm_rst <= (w_state_nxt == CLR);
            if (w_accept) begin
                r_x   <= in_x;
                r_ysh <= in_y;
            end else if (r_state == RUN) begin
                r_ysh <= r_ysh >>> 1;
            end
            if (r_state == CLR) begin
                r_k <= '0;
            end else if (r_state == RUN && !w_last) begin
                r_k <= r_k + CW'(1);
            end
        end
    end

    spm_deser #(
        .SIZE      (SIZE)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .i_shift   (w_shift),
        .i_bit     (spm_p),
`ifdef SPM_DRV_ACCUM_EN
        .i_last    (w_last),
        .i_acc_clr (acc_clr),
`endif
        .o_product (out_product)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign spm_rst   = r_spm_rst;
    assign spm_x     = r_x;
    assign spm_y     = w_spm_y;

endmodule
